// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared states, result codes and parity helper for the PS/2 host transmitter
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        ACK,
        WAIT_IDLE,
        DONE
    } ps2_state_t;

    localparam logic [1:0] PS2_OK      = 2'd0;
    localparam logic [1:0] PS2_NACK    = 2'd1;
    localparam logic [1:0] PS2_TIMEOUT = 2'd2;

    localparam int PS2_RETRY_MAX = 2;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - pad synchroniser plus ce-paced glitch filter with filtered falling-edge pulse
module ps2_line_filter #(
    parameter int FILT = 8
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic ce,
    input  logic line,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILT + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    // Lines idle high, so reset to the released level to avoid a spurious fall.
    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            sync  <= 2'b11;
            level <= 1'b1;
            cnt   <= '0;
            fall  <= 1'b0;
        end else begin
            sync <= {sync[0], line};
            fall <= 1'b0;
            if (ce) begin
                if (sync[1] == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(FILT - 1)) begin
                    level <= sync[1];
                    cnt   <= '0;
                    fall  <= level;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter driving open-drain clk/data enables
// Optional: define PS2_HOST_TX_RETRY_EN to retry a NACKed or timed-out byte up to two more times.
module ps2_host_tx #(
    parameter int CE_KHZ     = 6000,
    parameter int INHIBIT_US = 120,
    parameter int TIMEOUT_MS = 15,
    parameter int FILT       = 8
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic [1:0] tx_err,
    output logic       busy,
    input  logic       ps2_clk_i,
    input  logic       ps2_data_i,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    import ps2_pkg::*;

    localparam int INHIBIT_TICKS = INHIBIT_US * CE_KHZ / 1000;
    localparam int TIMEOUT_TICKS = TIMEOUT_MS * CE_KHZ;

    ps2_state_t  state;
    logic [8:0]  frame_q;
    logic [8:0]  shreg;
    logic [16:0] tick_cnt;
    logic [3:0]  edge_cnt;
    logic [1:0]  result;
    logic        clk_lvl;
    logic        clk_fall;
    logic        data_lvl;
    logic        data_fall_unused;
    logic        retry_ok;

    ps2_line_filter #(.FILT(FILT)) u_clk_filt (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .ce      (ce),
        .line    (ps2_clk_i),
        .level   (clk_lvl),
        .fall    (clk_fall)
    );

    ps2_line_filter #(.FILT(FILT)) u_data_filt (
        .clk_sys (clk_sys),
        .rst_n   (rst_n),
        .ce      (ce),
        .line    (ps2_data_i),
        .level   (data_lvl),
        .fall    (data_fall_unused)
    );

`ifdef PS2_HOST_TX_RETRY_EN
    logic [1:0] attempt;
    assign retry_ok = (attempt != 2'(PS2_RETRY_MAX));
`else
    assign retry_ok = 1'b0;
`endif

    assign busy = ~tx_ready;

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            tx_done     <= 1'b0;
            tx_err      <= PS2_OK;
            frame_q     <= '0;
            shreg       <= '0;
            tick_cnt    <= '0;
            edge_cnt    <= '0;
            result      <= PS2_OK;
`ifdef PS2_HOST_TX_RETRY_EN
            attempt     <= '0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        frame_q    <= {odd_parity(tx_data), tx_data};
                        ps2_clk_oe <= 1'b1;
                        tick_cnt   <= '0;
                        edge_cnt   <= '0;
                        tx_ready   <= 1'b0;
                        state      <= INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                        attempt    <= '0;
`endif
                    end
                end
                INHIBIT: begin
                    if (ce) begin
                        if (tick_cnt == 17'(INHIBIT_TICKS - 1)) begin
                            ps2_clk_oe  <= 1'b0;
                            ps2_data_oe <= 1'b1;
                            shreg       <= frame_q;
                            tick_cnt    <= '0;
                            state       <= REQ;
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (result != PS2_OK && retry_ok) begin
`ifdef PS2_HOST_TX_RETRY_EN
                        attempt    <= attempt + 1'b1;
`endif
                        ps2_clk_oe <= 1'b1;
                        tick_cnt   <= '0;
                        edge_cnt   <= '0;
                        state      <= INHIBIT;
                    end else begin
                        tx_done  <= 1'b1;
                        tx_err   <= result;
                        tx_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    // Timeout wins over a clock fall landing on the same cycle.
                    if (ce && tick_cnt == 17'(TIMEOUT_TICKS - 1)) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        if (retry_ok) begin
                            result <= PS2_TIMEOUT;
                            state  <= DONE;
                        end else begin
                            tx_done  <= 1'b1;
                            tx_err   <= PS2_TIMEOUT;
                            tx_ready <= 1'b1;
                            state    <= IDLE;
                        end
                    end else begin
                        if (ce) begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                        case (state)
                            REQ, DATA: begin
                                // Shifting in ones makes the tenth fall emit the released stop bit.
                                if (clk_fall) begin
                                    ps2_data_oe <= ~shreg[0];
                                    shreg       <= {1'b1, shreg[8:1]};
                                    edge_cnt    <= edge_cnt + 1'b1;
                                    state       <= (edge_cnt == 4'd9) ? ACK : DATA;
                                end
                            end
                            ACK: begin
                                if (clk_fall) begin
                                    edge_cnt <= 4'd11;
                                    result   <= data_lvl ? PS2_NACK : PS2_OK;
                                    state    <= WAIT_IDLE;
                                end
                            end
                            WAIT_IDLE: begin
                                if (clk_lvl && data_lvl) begin
                                    state <= DONE;
                                end
                            end
                            default: begin
                            end
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - directed bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;

    localparam int INH_TICKS = 720;
    localparam int TO_MS     = 1;   // shortened timeout keeps the run brief
    localparam int TO_TICKS  = 6000;
    localparam int H         = 40;
`ifdef PS2_HOST_TX_RETRY_EN
    localparam int ATTEMPTS = 3;
`else
    localparam int ATTEMPTS = 1;
`endif

    logic       clk_sys;
    logic       rst_n;
    logic       ce;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic [1:0] tx_err;
    logic       busy;
    logic       ps2_clk_i;
    logic       ps2_data_i;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       dev_clk;
    logic       dev_data;

    int         checks = 0;
    int         failures = 0;
    int         done_total = 0;
    logic [1:0] last_err = 2'd0;

    assign ps2_clk_i  = ~ps2_clk_oe & dev_clk;
    assign ps2_data_i = ~ps2_data_oe & dev_data;

    ps2_host_tx #(
        .CE_KHZ     (6000),
        .INHIBIT_US (120),
        .TIMEOUT_MS (TO_MS),
        .FILT       (8)
    ) dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .ce          (ce),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .busy        (busy),
        .ps2_clk_i   (ps2_clk_i),
        .ps2_data_i  (ps2_data_i),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    initial begin
        ce = 1'b0;
        forever begin
            @(posedge clk_sys);
            #1 ce = ~ce;
        end
    end

    always @(negedge clk_sys) begin
        if (tx_done) begin
            done_total <= done_total + 1;
            last_err   <= tx_err;
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
    endtask

    task automatic wait_done(input int base);
        for (int c = 0; c < 2000; c++) begin
            if (done_total != base) break;
            cyc(1);
        end
    endtask

    task automatic dev_frame(input int nfalls, input bit ack, input bit glitch, input bit poke,
                             output logic [10:0] fr, output int inh, output logic poke_ready);
        bit started;
        started    = 1'b0;
        fr         = '1;
        inh        = 0;
        poke_ready = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk_sys);
            if (ce && ps2_clk_oe) inh++;
            if (!ps2_clk_oe && ps2_data_oe) begin
                started = 1'b1;
                break;
            end
        end
        chk("start_seen", 32'(started), 32'd1);
        if (!started) return;
        cyc(1);
        fr[0] = ps2_data_i;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11 && ack) dev_data = 1'b0;
            cyc(H);
            dev_clk = 1'b0;
            cyc(H);
            if (i <= 10) fr[i] = ps2_data_i;
            dev_clk = 1'b1;
            if (glitch && i == 4) begin
                cyc(H / 2);
                dev_clk = 1'b0;
                cyc(4);
                dev_clk = 1'b1;
            end
            if (poke && i == 3) begin
                tx_data  = 8'h55;
                tx_valid = 1'b1;
                cyc(1);
                poke_ready = tx_ready;
                tx_valid = 1'b0;
            end
        end
        if (nfalls == 11 && ack) begin
            cyc(H);
            dev_data = 1'b1;
        end
    endtask

    task automatic full_frame(input logic [7:0] b, input logic par, input bit glitch,
                              input bit poke, input string tag);
        logic [10:0] fr;
        int          inh;
        logic        pr;
        int          base;
        base = done_total;
        send(b);
        dev_frame(11, 1'b1, glitch, poke, fr, inh, pr);
        chk({tag, "_start"},  32'(fr[0]),    32'd0);
        chk({tag, "_data"},   32'(fr[8:1]),  32'(b));
        chk({tag, "_parity"}, 32'(fr[9]),    32'(par));
        chk({tag, "_stop"},   32'(fr[10]),   32'd1);
        chk({tag, "_inhibit"}, 32'(inh),     32'(INH_TICKS));
        wait_done(base);
        chk({tag, "_done"},   32'(done_total - base), 32'd1);
        chk({tag, "_err"},    32'(last_err), 32'd0);
        if (poke) chk({tag, "_busy_ready"}, 32'(pr), 32'd0);
    endtask

    initial begin
        logic [10:0] fr;
        int          inh;
        logic        pr;
        int          base;
        int          n_inh;
        int          n_to;
        bit          seen;

        rst_n    = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        dev_clk  = 1'b1;
        dev_data = 1'b1;
        cyc(4);
        rst_n = 1'b1;
        cyc(2);
        chk("rst_ready",  32'(tx_ready),    32'd1);
        chk("rst_busy",   32'(busy),        32'd0);
        chk("rst_clk_oe", 32'(ps2_clk_oe),  32'd0);
        chk("rst_dat_oe", 32'(ps2_data_oe), 32'd0);
        chk("rst_done",   32'(tx_done),     32'd0);
        chk("rst_err",    32'(tx_err),      32'd0);

        // ED: bits LSB first 1,0,1,1,0,1,1,1, six ones so odd parity is 1
        full_frame(8'hED, 1'b1, 1'b0, 1'b0, "ed");
        full_frame(8'h00, 1'b1, 1'b0, 1'b0, "x00");
        full_frame(8'hFF, 1'b1, 1'b0, 1'b0, "xff");

        base = done_total;
        send(8'hF4);
        for (int a = 0; a < ATTEMPTS; a++) begin
            dev_frame(11, 1'b0, 1'b0, 1'b0, fr, inh, pr);
            chk("nack_data",    32'(fr[8:1]), 32'h0F4);
            chk("nack_inhibit", 32'(inh),     32'(INH_TICKS));
        end
        wait_done(base);
        chk("nack_done", 32'(done_total - base), 32'd1);
        chk("nack_err",  32'(last_err),          32'd1);

        send(8'h3C);
        n_inh = 0;
        n_to  = 0;
        seen  = 1'b0;
        for (int c = 0; c < ATTEMPTS * (2 * (TO_TICKS + INH_TICKS) + 200); c++) begin
            @(negedge clk_sys);
            if (tx_done) begin
                seen = 1'b1;
                break;
            end
            if (ce && ps2_clk_oe) n_inh++;
            if (ce && ps2_data_oe) n_to++;
        end
        chk("to_seen",    32'(seen),        32'd1);
        chk("to_err",     32'(tx_err),      32'd2);
        chk("to_ticks",   32'(n_to),        32'(ATTEMPTS * TO_TICKS));
        chk("to_inhibit", 32'(n_inh),       32'(ATTEMPTS * INH_TICKS));
        chk("to_clk_oe",  32'(ps2_clk_oe),  32'd0);
        chk("to_dat_oe",  32'(ps2_data_oe), 32'd0);
        cyc(4);
        chk("to_ready",   32'(tx_ready),    32'd1);

        // abort after fall 5: ED bit 4 is 0, so data is being pulled low
        send(8'hED);
        dev_frame(5, 1'b1, 1'b0, 1'b0, fr, inh, pr);
        chk("abort_pre_dat_oe", 32'(ps2_data_oe), 32'd1);
        rst_n = 1'b0;
        cyc(1);
        chk("abort_clk_oe", 32'(ps2_clk_oe),  32'd0);
        chk("abort_dat_oe", 32'(ps2_data_oe), 32'd0);
        chk("abort_ready",  32'(tx_ready),    32'd1);
        rst_n = 1'b1;
        cyc(4);
        full_frame(8'hA5, 1'b1, 1'b0, 1'b0, "after_rst");

        // F4 has five ones, so odd parity is 0
        full_frame(8'hF4, 1'b0, 1'b1, 1'b1, "glitch");
        cyc(200);
        chk("no_queue_clk_oe", 32'(ps2_clk_oe), 32'd0);
        chk("no_queue_ready",  32'(tx_ready),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
